// File: rtl/mux_array_dw.sv
// Registered logarithmic barrel shifter for significand alignment/normalisation.
// Shifts Data_i left or right by 0..2^EWR-1 places, filling vacated bits with bit_shift_i.
module mux_array_dw #(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    input  logic           FSM_left_right_i,
    input  logic [EWR-1:0] Shift_Value_i,
    input  logic           bit_shift_i,
    output logic [SWR-1:0] Data_o
);

    // Interface timing: there is no valid/ready pair. Every rising edge with
    // load_i=1 captures a new operation; load_i=0 holds Data_o unchanged.

    logic [SWR-1:0]           data_rev;
    logic [EWR:0][SWR-1:0]    stage;
    logic [SWR-1:0]           stage_rev;
    logic [SWR-1:0]           result;

    genvar i, k;

    // Left shifts reuse the right-shift network on bit-reversed data.
    for (i = 0; i < SWR; i++) begin : g_rev_in
        assign data_rev[i] = Data_i[SWR-1-i];
    end

    assign stage[0] = FSM_left_right_i ? data_rev : Data_i;

    // Stage k moves bits down by 2^k; positions past the top take the fill bit,
    // so shift amounts of SWR or more yield an all-fill word with no wrap.
    for (k = 0; k < EWR; k++) begin : g_stage
        for (i = 0; i < SWR; i++) begin : g_bit
            if (i + (1 << k) < SWR) begin : g_take
                assign stage[k+1][i] = Shift_Value_i[k] ? stage[k][i + (1 << k)]
                                                        : stage[k][i];
            end else begin : g_fill
                assign stage[k+1][i] = Shift_Value_i[k] ? bit_shift_i
                                                        : stage[k][i];
            end
        end
    end

    for (i = 0; i < SWR; i++) begin : g_rev_out
        assign stage_rev[i] = stage[EWR][SWR-1-i];
    end

    assign result = FSM_left_right_i ? stage_rev : stage[EWR];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_o <= '0;
        end else if (load_i) begin
            Data_o <= result;
        end
    end

endmodule

// File: tb/tb_mux_array_dw.sv
// Directed self-checking bench for mux_array_dw: reset, both shift directions,
// fill behaviour, out-of-range shifts, load hold, mid-stream reset and an S sweep.
module tb_mux_array_dw;

    localparam int SWR = 26;
    localparam int EWR = 5;

    logic           clk;
    logic           rst;
    logic           load_i;
    logic [SWR-1:0] Data_i;
    logic           FSM_left_right_i;
    logic [EWR-1:0] Shift_Value_i;
    logic           bit_shift_i;
    logic [SWR-1:0] Data_o;

    int n_cmp = 0;
    int n_err = 0;

    mux_array_dw #(.SWR(SWR), .EWR(EWR)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_i           (load_i),
        .Data_i           (Data_i),
        .FSM_left_right_i (FSM_left_right_i),
        .Shift_Value_i    (Shift_Value_i),
        .bit_shift_i      (bit_shift_i),
        .Data_o           (Data_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [SWR-1:0] shift_model(input logic [SWR-1:0] d, input logic left,
                                                   input int s, input logic fill);
        logic [SWR-1:0] r;
        for (int b = 0; b < SWR; b++) begin
            if (left) r[b] = (b >= s) ? d[b - s] : fill;
            else      r[b] = (b + s <= SWR - 1) ? d[b + s] : fill;
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Drive on the falling edge, let one rising edge capture, sample 1 ns later.
    task automatic drive_op(input logic [SWR-1:0] d, input logic left, input logic [EWR-1:0] s,
                            input logic fill, input logic ld);
        @(negedge clk);
        Data_i           = d;
        FSM_left_right_i = left;
        Shift_Value_i    = s;
        bit_shift_i      = fill;
        load_i           = ld;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst              = 1'b0;
        load_i           = 1'b1;
        Data_i           = 26'h3FFFFFF;
        FSM_left_right_i = 1'b0;
        Shift_Value_i    = '0;
        bit_shift_i      = 1'b1;
        #3;
        n_cmp++;
        if (Data_o !== 26'h0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", Data_o, 26'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (Data_o !== 26'h0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected %h", Data_o, 26'h0);
        end
        @(negedge clk);
        load_i = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (Data_o !== 26'h0) begin
            n_err++;
            $display("FAIL reset_release_noload: got %h expected %h", Data_o, 26'h0);
        end
    endtask

    task automatic test_right_shift();
        drive_op(26'h2000001, 1'b0, 5'd1, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h1000000) begin
            n_err++;
            $display("FAIL right_s1: got %h expected %h", Data_o, 26'h1000000);
        end
        drive_op(26'h2000000, 1'b0, 5'd25, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h0000001) begin
            n_err++;
            $display("FAIL right_s25: got %h expected %h", Data_o, 26'h0000001);
        end
        drive_op(26'h0000000, 1'b0, 5'd3, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h3800000) begin
            n_err++;
            $display("FAIL right_fill1_s3: got %h expected %h", Data_o, 26'h3800000);
        end
    endtask

    task automatic test_left_shift();
        drive_op(26'h0000001, 1'b1, 5'd4, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h0000010) begin
            n_err++;
            $display("FAIL left_fill0_s4: got %h expected %h", Data_o, 26'h0000010);
        end
        drive_op(26'h0000001, 1'b1, 5'd4, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h000001F) begin
            n_err++;
            $display("FAIL left_fill1_s4: got %h expected %h", Data_o, 26'h000001F);
        end
    endtask

    task automatic test_boundaries();
        drive_op(26'h2AAAAAA, 1'b0, 5'd0, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h2AAAAAA) begin
            n_err++;
            $display("FAIL s0_right: got %h expected %h", Data_o, 26'h2AAAAAA);
        end
        drive_op(26'h2AAAAAA, 1'b1, 5'd0, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h2AAAAAA) begin
            n_err++;
            $display("FAIL s0_left: got %h expected %h", Data_o, 26'h2AAAAAA);
        end
        drive_op(26'h1555555, 1'b0, 5'd26, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h3FFFFFF) begin
            n_err++;
            $display("FAIL s26_fill1: got %h expected %h", Data_o, 26'h3FFFFFF);
        end
        drive_op(26'h1555555, 1'b1, 5'd31, 1'b1, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h3FFFFFF) begin
            n_err++;
            $display("FAIL s31_fill1: got %h expected %h", Data_o, 26'h3FFFFFF);
        end
        drive_op(26'h3FFFFFF, 1'b1, 5'd26, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h0000000) begin
            n_err++;
            $display("FAIL s26_fill0: got %h expected %h", Data_o, 26'h0000000);
        end
        drive_op(26'h3FFFFFF, 1'b0, 5'd31, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h0000000) begin
            n_err++;
            $display("FAIL s31_fill0: got %h expected %h", Data_o, 26'h0000000);
        end
    endtask

    task automatic test_load_hold();
        drive_op(26'h1234567, 1'b0, 5'd0, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h1234567) begin
            n_err++;
            $display("FAIL hold_load: got %h expected %h", Data_o, 26'h1234567);
        end
        drive_op(26'h3FFFFFF, 1'b1, 5'd7, 1'b1, 1'b0);
        n_cmp++;
        if (Data_o !== 26'h1234567) begin
            n_err++;
            $display("FAIL hold_cycle1: got %h expected %h", Data_o, 26'h1234567);
        end
        drive_op(26'h0000000, 1'b0, 5'd13, 1'b0, 1'b0);
        n_cmp++;
        if (Data_o !== 26'h1234567) begin
            n_err++;
            $display("FAIL hold_cycle2: got %h expected %h", Data_o, 26'h1234567);
        end
    endtask

    task automatic test_reset_midstream();
        drive_op(26'h0ABCDEF, 1'b0, 5'd0, 1'b0, 1'b1);
        // Present a new operation, then pulse reset before its capturing edge.
        Data_i = 26'h3C3C3C3;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (Data_o !== 26'h0) begin
            n_err++;
            $display("FAIL midreset_async: got %h expected %h", Data_o, 26'h0);
        end
        @(negedge clk);
        rst    = 1'b1;
        load_i = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (Data_o !== 26'h0) begin
            n_err++;
            $display("FAIL midreset_discard: got %h expected %h", Data_o, 26'h0);
        end
        drive_op(26'h0000003, 1'b1, 5'd2, 1'b0, 1'b1);
        n_cmp++;
        if (Data_o !== 26'h000000C) begin
            n_err++;
            $display("FAIL midreset_reload: got %h expected %h", Data_o, 26'h000000C);
        end
    endtask

    task automatic test_back_to_back_sweep();
        logic [SWR-1:0] d;
        logic [SWR-1:0] exp_v;
        logic           left;
        logic           fill;
        for (int s = 0; s < 32; s++) begin
            d     = 26'h2C3A5F1 ^ (26'h0111111 * s);
            left  = s[0];
            fill  = s[1];
            exp_v = shift_model(d, left, s, fill);
            drive_op(d, left, s[EWR-1:0], fill, 1'b1);
            n_cmp++;
            if (Data_o !== exp_v) begin
                n_err++;
                $display("FAIL sweep_s%0d dir=%0d fill=%0d: got %h expected %h",
                         s, left, fill, Data_o, exp_v);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_right_shift();
        test_left_shift();
        test_boundaries();
        test_load_hold();
        test_reset_midstream();
        test_back_to_back_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_array_dw.md
Name: mux_array_dw

Overview:
- Registered logarithmic barrel shifter for the floating-point add/subtract datapath (mantissa normalisation/alignment).
- Shifts an SWR-bit significand left or right by 0..2^EWR-1 positions.
- Vacated positions are filled with a selectable fill bit.
- Result is captured in an output register under a load enable.

Parameters:
SWR, 26, significand word width in bits (Data_i/Data_o width)
EWR, 5, shift-amount width in bits; shift range 0..2^EWR-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
load_i  input  1  output register load enable
Data_i  input  SWR  data to shift
FSM_left_right_i  input  1  direction: 1 = left shift, 0 = right shift
Shift_Value_i  input  EWR  shift amount, unsigned
bit_shift_i  input  1  fill bit for vacated positions
Data_o  output  SWR  registered shifted result

Behaviour:
- Reset: rst low forces Data_o to all zeros immediately, independent of clk, and holds it while low. The first capture occurs on the first rising edge after rst goes high with load_i=1.
- Datapath is combinational from Data_i, FSM_left_right_i, Shift_Value_i and bit_shift_i to the register input.
- Implementation: EWR cascaded 2:1 mux stages. Stage k shifts by 2^k when Shift_Value_i[k]=1.
- Left shift is realised by bit-reversing the input, right-shifting, and bit-reversing the result.
- Right shift: result[i] = Data_i[i+S] for i+S <= SWR-1, otherwise bit_shift_i (S = Shift_Value_i).
- Left shift: result[i] = Data_i[i-S] for i >= S, otherwise bit_shift_i.
- S = 0: result = Data_i, for either direction and either fill bit.
- S >= SWR (e.g. 26..31 with defaults): every result bit = bit_shift_i. No wrap-around, no modulo on S.
- Register: on a rising clk with rst high and load_i=1, Data_o <= result. With load_i=0, Data_o holds its value.
- Latency: exactly 1 clock from input change to Data_o when load_i=1. No handshake and no busy state; a new operation is accepted every cycle.
- All inputs are sampled only at the capturing edge; changes between edges have no effect on Data_o.
- rst asserted mid-operation: the pending result is discarded and Data_o = 0 until a load after reset release.
- No state machine.

Test Plan:
- Reset: rst=0, load_i=1, any Data_i -> Data_o = 26'h0000000 asynchronously; it stays 0 until the first load edge after rst=1.
- Right shift, zero fill: Data_i=26'h2000001, S=1, FSM_left_right_i=0, bit_shift_i=0, load_i=1 -> Data_o = 26'h1000000 one cycle later. Then S=25 with Data_i=26'h2000000 -> Data_o = 26'h0000001.
- Left shift, fill bit: Data_i=26'h0000001, S=4, FSM_left_right_i=1, bit_shift_i=0 -> 26'h0000010. Same operation with bit_shift_i=1 -> 26'h000001F.
- Right shift, fill bit: Data_i=26'h0000000, S=3, FSM_left_right_i=0, bit_shift_i=1 -> 26'h3800000.
- Boundaries:
  - S=0 with Data_i=26'h2AAAAAA -> Data_o = 26'h2AAAAAA for both directions.
  - S=26 and S=31 with bit_shift_i=1 -> 26'h3FFFFFF.
  - S=26 and S=31 with bit_shift_i=0 -> 26'h0000000.
- Load hold and reset mid-stream:
  - Load 26'h1234567 with S=0, then set load_i=0 and change all inputs -> Data_o holds 26'h1234567.
  - Pulse rst low between edges -> Data_o = 0 immediately.
  - Sweep S=0..31 with alternating direction -> each output matches the shift formula.
